regwrite_scheduler: RTL
=======================

# regwrite_scheduler

Two-requester write-port scheduler for the register file. It arbitrates round-robin between two write sources, such as the ALU writeback and the memory writeback, and registers the winning address and data into a single output stage. It drives the register file's write enable, write address, write data and one-hot row select. The row select comes from an internal address decoder gated by the write enable.

## Interface
Parameters:
- ADDR_W, 5, register address width; 2**ADDR_W registers.
- DATA_W, 64, write data width.
- ZERO_REG, 2**ADDR_W-1, hard-wired zero register; writes to it are discarded.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
- req_valid  in  2  per-requester write request.
- req_ready  out  2  per-requester accept; a transfer occurs when req_valid[i] && req_ready[i].
- req_addr0, req_addr1  in  ADDR_W  destination register per requester.
- req_data0, req_data1  in  DATA_W  write data per requester.
- port_stall  in  1  register file cannot take a write this cycle.
- wr_en  out  1  output stage holds a valid write.
- wr_addr  out  ADDR_W  registered write address.
- wr_data  out  DATA_W  registered write data.
- wr_sel  out  2**ADDR_W  one-hot decode of wr_addr, gated by wr_en; all-zero when wr_en=0.
- grant_id  out  1  requester that owns the write currently in the output stage.

## Operation
- FSM, two states:
  - EMPTY: output stage holds no write; wr_en=0.
  - FULL: output stage holds a write; wr_en=1.
- Drain: a FULL stage retires on a cycle with port_stall=0.
- Accept condition: accept = (state==EMPTY) || !port_stall. This is a single-entry pipeline with drain-and-refill in the same cycle.
- Arbitration when accept=1:
  - Only one requester valid: that requester wins.
  - Both valid: the requester other than rr_last wins.
  - req_ready is asserted only for the winner. req_ready is combinational from req_valid, rr_last, state and port_stall. It never depends on req_data or req_addr.
- rr_last updates to the winner on each transfer only. It is unchanged on idle and stall cycles.
- Transfer with address == ZERO_REG:
  - The request is acknowledged (req_ready=1) and rr_last updates.
  - The output stage does not load it. The next state is EMPTY unless the stage was FULL and stalled. (A FULL stalled stage cannot accept, so it stays FULL.)
- Transfer with any other address: the stage loads wr_addr, wr_data and grant_id; next state is FULL.
- State transitions:
  - EMPTY→FULL on a non-zero transfer.
  - FULL→EMPTY on drain with no non-zero transfer.
  - FULL→FULL when stalled, or on drain plus a non-zero transfer.
- Requesters hold valid, addr and data stable until ready (the valid/ready contract). The block does not check this.

## Timing
- Reset (reset_n=0 at a clock edge) forces:
  - state=EMPTY, wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, grant_id=0.
  - rr_last=1, so requester 0 wins the first contention.
- req_ready is 0 during reset.
- Reset mid-operation drops any held write. No write is issued on the reset cycle or the cycle after.
- Latency: a request accepted at edge N appears on wr_en/wr_addr/wr_data at edge N+1. wr_sel is valid the same cycle as wr_addr (combinational decode of registered outputs).
- Throughput: one write per cycle while port_stall=0.
- Under continuous contention, grants strictly alternate 0,1,0,1.
- While port_stall=1 and FULL:
  - All outputs are held bit-stable.
  - req_ready=0.
  - rr_last is frozen.
- Stall release: when port_stall falls, the held write retires at that edge and a new winner loads in the same edge, with no bubble.

## Structure
- Package regwrite_pkg holds:
  - ADDR_W/DATA_W defaults and ZERO_REG.
  - typedef enum logic {EMPTY, FULL} wstate_t.
  - typedef struct {addr, data} wreq_t.
- One sub-module, wr_decoder (ADDR_W → 2**ADDR_W one-hot, with enable input). It is built hierarchically from 1-to-2 enable decoders; en=wr_en.
- Remaining logic (arbiter, FSM, output register) stays flat in regwrite_scheduler.

## Test plan
- Reset: hold reset_n=0 with both req_valid=1 → req_ready=00, wr_en=0, wr_sel=0. Release: first grant goes to requester 0, and wr_en=1 next cycle.
- Contention: both valid for 6 cycles with addr0=3, addr1=7, port_stall=0 → grant_id sequence 0,1,0,1,0,1; wr_sel alternates 0x8 / 0x80.
- Stall: FULL with addr=5, port_stall=1 for 3 cycles → outputs stable, req_ready=00. port_stall→0 → the addr=5 write retires and a pending requester loads on the same edge.
- Zero register: req0 addr=31 data=0xDEAD alone → req_ready[0]=1, wr_en stays 0, wr_sel=0. A following contention grants requester 1 first.
- Reset mid-stall: FULL with addr=9, port_stall=1, then reset_n=0 for one cycle → wr_en=0, wr_sel=0 after the edge; the addr=9 write is never issued.

Source files
------------

// File: rtl/regwrite_pkg.sv
// Shared types and defaults for the register-file write-port scheduler.
package regwrite_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 64;
  localparam int ZERO_REG_DEF = 2**ADDR_W_DEF - 1;

  typedef enum logic {EMPTY, FULL} wstate_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wreq_t;

  // 1-to-2 enable decoder: {hi, lo}
  function automatic logic [1:0] dec1to2(input logic en, input logic a);
    return {en & a, en & ~a};
  endfunction

endpackage

// File: rtl/regwrite_scheduler_wr_decoder.sv
// One-hot row-select decoder built as a binary tree of 1-to-2 enable decoders.
module wr_decoder
  import regwrite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 en_i,
  input  logic [ADDR_W-1:0]    addr_i,
  output logic [2**ADDR_W-1:0] sel_o
);

  localparam int NODES = 2**(ADDR_W+1) - 1;

  // Heap-ordered tree: node k feeds 2k+1 (bit=0) and 2k+2 (bit=1); MSB decoded first
  logic [NODES-1:0] node;

  always_comb begin
    node    = '0;
    node[0] = en_i;
    for (int l = 0; l < ADDR_W; l++) begin
      for (int i = 0; i < 2**l; i++) begin
        node[2*(2**l-1+i)+2 -: 2] = dec1to2(node[2**l-1+i], addr_i[ADDR_W-1-l]);
      end
    end
  end

  assign sel_o = node[NODES-1 -: 2**ADDR_W];

endmodule

// File: rtl/regwrite_scheduler.sv
// Two-requester round-robin write-port scheduler feeding a single registered write stage.
module regwrite_scheduler
  import regwrite_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ZERO_REG = 2**ADDR_W - 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [ADDR_W-1:0]    req_addr0,
  input  logic [ADDR_W-1:0]    req_addr1,
  input  logic [DATA_W-1:0]    req_data0,
  input  logic [DATA_W-1:0]    req_data1,
  input  logic                 port_stall,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] wr_sel,
  output logic                 grant_id
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  wstate_t           state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              gid_q, gid_d;

  logic accept, win, xfer, load;
  req_t req_w;

  always_comb begin
    accept    = (state_q == EMPTY) || !port_stall;
    // Lone requester wins outright; under contention the one not served last wins
    win       = (&req_valid) ? ~rr_last_q : req_valid[1];
    xfer      = reset_n && accept && (|req_valid);
    req_ready = {xfer & win, xfer & ~win};
    req_w     = win ? req_t'{req_addr1, req_data1} : req_t'{req_addr0, req_data0};
    // Zero-register writes are acknowledged but never occupy the stage
    load      = xfer && (req_w.addr != ADDR_W'(ZERO_REG));

    state_d   = state_q;
    rr_last_d = xfer ? win : rr_last_q;
    addr_d    = addr_q;
    data_d    = data_q;
    gid_d     = gid_q;

    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (!port_stall && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (load) begin
      addr_d = req_w.addr;
      data_d = req_w.data;
      gid_d  = win;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      gid_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      gid_q     <= gid_d;
    end
  end

  assign wr_en    = (state_q == FULL);
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign grant_id = gid_q;

  wr_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .en_i   (wr_en),
    .addr_i (addr_q),
    .sel_o  (wr_sel)
  );

endmodule
